// File: rtl/me_pkg.sv
// Shared types and sizing helpers for the full-search block-matching motion estimator.
package me_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Accumulator width large enough for N*N maximal absolute differences.
  function automatic int unsigned sad_w(input int unsigned block_n, input int unsigned pixel_w);
    return pixel_w + 2 * $clog2(block_n);
  endfunction

  function automatic int unsigned mv_w(input int unsigned search_p);
    return $clog2(search_p + 1) + 1;
  endfunction

  // Search-window linear address of reference pixel (i,j) for candidate (x,y) in 0..2P form.
  function automatic int unsigned win_offset(input int unsigned i, input int unsigned j,
                                             input int unsigned x, input int unsigned y,
                                             input int unsigned win_w);
    return (i + y) * win_w + (j + x);
  endfunction

endpackage

// File: rtl/me_sad_pe.sv
// SAD processing element: absolute difference, per-candidate accumulator and the
// partial-vs-threshold compare used to abandon losing candidates.
module me_sad_pe #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned SAD_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_valid,
  input  logic               i_first,
  input  logic [PIXEL_W-1:0] i_r,
  input  logic [PIXEL_W-1:0] i_s,
  input  logic [SAD_W-1:0]   i_thresh,
  output logic [SAD_W-1:0]   o_sad,
  output logic               o_ge
);

  logic [PIXEL_W-1:0] w_diff;
  logic [SAD_W-1:0]   w_partial;
  logic [SAD_W-1:0]   r_acc;

  always_comb begin
    w_diff    = (i_r > i_s) ? (i_r - i_s) : (i_s - i_r);
    // First pixel of a candidate restarts the sum instead of adding to the previous one.
    w_partial = (i_first ? '0 : r_acc) + SAD_W'(w_diff);
    o_ge      = (w_partial >= i_thresh);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_valid) begin
      r_acc <= w_partial;
    end
  end

  assign o_sad = r_acc;

endmodule

// File: rtl/motion_search_core.sv
// Full-search motion estimator: FSM, raster address generation over (y,x,i,j),
// read pipeline tags and the best-candidate registers.
module motion_search_core
  import me_pkg::*;
#(
  parameter int unsigned BLOCK_N  = 16,
  parameter int unsigned SEARCH_P = 8,
  parameter int unsigned PIXEL_W  = 8,
  localparam int unsigned WIN_W   = BLOCK_N + 2 * SEARCH_P,
  localparam int unsigned AR_W    = $clog2(BLOCK_N * BLOCK_N),
  localparam int unsigned AS_W    = $clog2(WIN_W * WIN_W),
  localparam int unsigned SAD_W   = sad_w(BLOCK_N, PIXEL_W),
  localparam int unsigned MV_W    = mv_w(SEARCH_P)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   early_term_en,
  output logic [AR_W-1:0]        address_r,
  input  logic [PIXEL_W-1:0]     r_data,
  output logic [AS_W-1:0]        address_s,
  input  logic [PIXEL_W-1:0]     s_data,
  output logic [SAD_W-1:0]       best_dist,
  output logic signed [MV_W-1:0] motion_x,
  output logic signed [MV_W-1:0] motion_y,
  output logic                   busy,
  output logic                   completed
);

  localparam int unsigned IW = $clog2(BLOCK_N);
  localparam int unsigned XW = $clog2(2 * SEARCH_P + 1);
  localparam logic [IW-1:0] IMax = IW'(BLOCK_N - 1);
  localparam logic [XW-1:0] XMax = XW'(2 * SEARCH_P);
  localparam logic signed [MV_W-1:0] MvOff = MV_W'(SEARCH_P);

  state_e r_state, w_state_nxt;
  logic   r_drain_cnt;
  logic   r_et_en;
  logic   w_launch;

  logic [IW-1:0] r_i, r_j;
  logic [XW-1:0] r_x, r_y;
  logic          r_all_issued;
  logic [AR_W-1:0] r_addr_r;
  logic [AS_W-1:0] r_addr_s;

  logic          r_a_valid, r_a_first, r_a_last;
  logic [XW-1:0] r_a_x, r_a_y;
  logic          r_b_valid, r_b_first, r_b_last;
  logic [XW-1:0] r_b_x, r_b_y;
  logic          r_c_last;
  logic [XW-1:0] r_c_x, r_c_y;

  logic [SAD_W-1:0]       r_best;
  logic signed [MV_W-1:0] r_mv_x, r_mv_y;

  logic [SAD_W-1:0] w_sad;
  logic             w_ge, w_abort, w_skip, w_skip_done, w_can_issue;
  logic [IW-1:0]    w_is_i, w_is_j;
  logic [XW-1:0]    w_is_x, w_is_y;

  assign w_launch = start && ((r_state == StIdle) || (r_state == StDone));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_nxt = StRun;
      StRun:   if (r_all_issued) w_state_nxt = StDrain;
      StDrain: if (r_drain_cnt) w_state_nxt = StDone;
      StDone:  if (start) w_state_nxt = StRun;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Abort never fires on a candidate's last pixel: the in-flight read then belongs to the next one.
  assign w_abort = r_et_en && r_b_valid && !r_b_last && w_ge;
  assign w_skip  = w_abort && !r_a_last;

  always_comb begin
    w_is_i      = r_i;
    w_is_j      = r_j;
    w_is_x      = r_x;
    w_is_y      = r_y;
    w_skip_done = 1'b0;
    if (w_skip) begin
      w_is_i = '0;
      w_is_j = '0;
      if (r_x == XMax) begin
        w_is_x = '0;
        w_is_y = r_y + 1'b1;
      end else begin
        w_is_x = r_x + 1'b1;
      end
      w_skip_done = (r_x == XMax) && (r_y == XMax);
    end
    w_can_issue = (r_state == StRun) && !r_all_issued && !w_skip_done;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_drain_cnt <= 1'b0;
      r_et_en     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == StDrain);
      if (w_launch) r_et_en <= early_term_en;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_i          <= '0;
      r_j          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_all_issued <= 1'b0;
      r_addr_r     <= '0;
      r_addr_s     <= '0;
      r_a_valid    <= 1'b0;
      r_a_first    <= 1'b0;
      r_a_last     <= 1'b0;
      r_a_x        <= '0;
      r_a_y        <= '0;
    end else if (w_launch) begin
      r_i          <= '0;
      r_j          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_all_issued <= 1'b0;
      r_a_valid    <= 1'b0;
    end else begin
      r_a_valid <= w_can_issue;
      if (w_can_issue) begin
        r_addr_r  <= {w_is_i, w_is_j};
        r_addr_s  <= AS_W'(win_offset(32'(w_is_i), 32'(w_is_j), 32'(w_is_x), 32'(w_is_y),
                                      WIN_W));
        r_a_first <= (w_is_i == '0) && (w_is_j == '0);
        r_a_last  <= (w_is_i == IMax) && (w_is_j == IMax);
        r_a_x     <= w_is_x;
        r_a_y     <= w_is_y;
        r_i       <= w_is_i;
        r_x       <= w_is_x;
        r_y       <= w_is_y;
        if (w_is_j != IMax) begin
          r_j <= w_is_j + 1'b1;
        end else begin
          r_j <= '0;
          if (w_is_i != IMax) begin
            r_i <= w_is_i + 1'b1;
          end else begin
            r_i <= '0;
            if (w_is_x != XMax) begin
              r_x <= w_is_x + 1'b1;
            end else begin
              r_x <= '0;
              r_y <= w_is_y + 1'b1;
              if (w_is_y == XMax) r_all_issued <= 1'b1;
            end
          end
        end
      end else if (w_skip_done) begin
        r_all_issued <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_b_valid <= 1'b0;
      r_b_first <= 1'b0;
      r_b_last  <= 1'b0;
      r_b_x     <= '0;
      r_b_y     <= '0;
      r_c_last  <= 1'b0;
      r_c_x     <= '0;
      r_c_y     <= '0;
    end else if (w_launch) begin
      r_b_valid <= 1'b0;
      r_c_last  <= 1'b0;
    end else begin
      r_b_valid <= r_a_valid && !w_abort;
      r_b_first <= r_a_first;
      r_b_last  <= r_a_last;
      r_b_x     <= r_a_x;
      r_b_y     <= r_a_y;
      r_c_last  <= r_b_valid && r_b_last;
      r_c_x     <= r_b_x;
      r_c_y     <= r_b_y;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_best <= '1;
      r_mv_x <= '0;
      r_mv_y <= '0;
    end else if (w_launch) begin
      r_best <= '1;
      r_mv_x <= '0;
      r_mv_y <= '0;
    end else if (r_c_last && (w_sad < r_best)) begin
      r_best <= w_sad;
      r_mv_x <= signed'(MV_W'(r_c_x)) - MvOff;
      r_mv_y <= signed'(MV_W'(r_c_y)) - MvOff;
    end
  end

  me_sad_pe #(
    .PIXEL_W(PIXEL_W),
    .SAD_W  (SAD_W)
  ) u_pe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (r_b_valid),
    .i_first (r_b_first),
    .i_r     (r_data),
    .i_s     (s_data),
    .i_thresh(r_best),
    .o_sad   (w_sad),
    .o_ge    (w_ge)
  );

  assign address_r = r_addr_r;
  assign address_s = r_addr_s;
  assign best_dist = r_best;
  assign motion_x  = r_mv_x;
  assign motion_y  = r_mv_y;
  assign busy      = (r_state == StRun) || (r_state == StDrain);
  assign completed = (r_state == StDone);

endmodule

// File: tb/tb_motion_search_core.sv
// Directed bench for motion_search_core (N=4, P=1) with a reference full-search model
// feeding a result scoreboard.
module tb_motion_search_core;

  localparam int W = 6;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              early_term_en = 1'b0;
  logic [3:0]        address_r;
  logic [5:0]        address_s;
  logic [7:0]        r_data, s_data;
  logic [11:0]       best_dist;
  logic signed [1:0] motion_x, motion_y;
  logic              busy, completed;

  motion_search_core #(
    .BLOCK_N (4),
    .SEARCH_P(1),
    .PIXEL_W (8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .early_term_en(early_term_en),
    .address_r    (address_r),
    .r_data       (r_data),
    .address_s    (address_s),
    .s_data       (s_data),
    .best_dist    (best_dist),
    .motion_x     (motion_x),
    .motion_y     (motion_y),
    .busy         (busy),
    .completed    (completed)
  );

  always #5 clock = ~clock;

  logic [7:0] rom_r[16];
  logic [7:0] rom_s[36];
  logic [7:0] img_r[16];

  always @(posedge clock) begin
    r_data <= rom_r[address_r];
    s_data <= rom_s[address_s];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int best;
    int mx;
    int my;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(output int best, output int mx, output int my);
    int sad, d;
    best = 4095;
    mx = 0;
    my = 0;
    for (int y = -1; y <= 1; y++) begin
      for (int x = -1; x <= 1; x++) begin
        sad = 0;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            d = int'(rom_r[i*4+j]) - int'(rom_s[(i+y+1)*W + j+x+1]);
            sad += (d < 0) ? -d : d;
          end
        end
        if (sad < best) begin
          best = sad;
          mx = x;
          my = y;
        end
      end
    end
  endfunction

  task automatic push_expect();
    exp_t e;
    model(e.best, e.mx, e.my);
    sb.push_back(e);
  endtask

  task automatic launch(input logic et, input bit hold, output int c0);
    push_expect();
    @(negedge clock);
    start = 1'b1;
    early_term_en = et;
    @(posedge clock);
    #1;
    c0 = cyc;
    if (!hold) begin
      start = 1'b0;
      early_term_en = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int c0, output int lat);
    exp_t e;
    lat = -1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clock);
      #1;
      if (completed) begin
        lat = cyc - c0;
        break;
      end
    end
    check({tag, "_completed"}, completed, 1);
    check({tag, "_sb_pending"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sb_best"}, best_dist, e.best);
      check({tag, "_sb_mx"}, motion_x, e.mx);
      check({tag, "_sb_my"}, motion_y, e.my);
    end
  endtask

  task automatic load_offset_image();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) rom_r[i*4+j] = img_r[i*4+j];
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        if (r < 4 && c >= 2) rom_s[r*W+c] = img_r[r*4 + (c-2)];
        else rom_s[r*W+c] = (img_r[(r%4)*4 + (c%4)] > 8'd205) ? 8'd255
                                                                : img_r[(r%4)*4 + (c%4)] + 8'd50;
      end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr_r"}, address_r, 0);
    check({tag, "_addr_s"}, address_s, 0);
    check({tag, "_best"}, best_dist, 4095);
    check({tag, "_mx"}, motion_x, 0);
    check({tag, "_my"}, motion_y, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_completed"}, completed, 0);
  endtask

  initial begin
    int c0, c1, lat;
    exp_t e;
    for (int i = 0; i < 16; i++) img_r[i] = 8'($urandom_range(0, 200));
    for (int i = 0; i < 16; i++) rom_r[i] = 8'd0;
    for (int i = 0; i < 36; i++) rom_s[i] = 8'd0;

    repeat (2) @(posedge clock);
    #1;
    check_reset_values("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Exact copy at (+1,-1), everything else offset by +50.
    load_offset_image();
    launch(1'b0, 1'b0, c0);
    check("s1_busy_run", busy, 1);
    check("s1_completed_run", completed, 0);
    wait_done("s1", c0, lat);
    check("s1_latency", lat, 147);
    check("s1_best", best_dist, 0);
    check("s1_mx", motion_x, 1);
    check("s1_my", motion_y, -1);

    // Flat images: every candidate ties at 0, the first one wins.
    for (int i = 0; i < 16; i++) rom_r[i] = 8'd7;
    for (int i = 0; i < 36; i++) rom_s[i] = 8'd7;
    launch(1'b0, 1'b0, c0);
    check("s2_completed_fall", completed, 0);
    check("s2_busy_rise", busy, 1);
    wait_done("s2", c0, lat);
    check("s2_best", best_dist, 0);
    check("s2_mx", motion_x, -1);
    check("s2_my", motion_y, -1);

    // Maximal SAD must fit without overflow.
    for (int i = 0; i < 16; i++) rom_r[i] = 8'd255;
    for (int i = 0; i < 36; i++) rom_s[i] = 8'd0;
    launch(1'b0, 1'b0, c0);
    wait_done("s3", c0, lat);
    check("s3_best", best_dist, 4080);
    check("s3_mx", motion_x, -1);
    check("s3_my", motion_y, -1);

    // Early termination: same answer, sooner.
    load_offset_image();
    launch(1'b1, 1'b0, c0);
    wait_done("s4", c0, lat);
    check("s4_faster", lat < 147, 1);
    check("s4_best", best_dist, 0);
    check("s4_mx", motion_x, 1);
    check("s4_my", motion_y, -1);

    // Asynchronous reset mid-search, then a clean rerun.
    launch(1'b0, 1'b0, c0);
    repeat (39) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("s5_async");
    e = sb.pop_front();
    @(negedge clock);
    reset_n = 1'b1;
    launch(1'b0, 1'b0, c0);
    wait_done("s5", c0, lat);
    check("s5_latency", lat, 147);
    check("s5_best", best_dist, 0);
    check("s5_mx", motion_x, 1);

    // start held high: back-to-back searches with a single DONE cycle between them.
    launch(1'b0, 1'b1, c0);
    push_expect();
    wait_done("s6a", c0, lat);
    check("s6a_latency", lat, 147);
    c1 = cyc;
    @(posedge clock);
    #1;
    check("s6_done_one_cycle", completed, 0);
    check("s6_busy_again", busy, 1);
    wait_done("s6b", c1, lat);
    check("s6b_latency", lat, 148);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("s6_done_hold", completed, 1);
    check("s6_best_hold", best_dist, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
